// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the unified memory port: arbiter FSM, port owner and byte-enable patterns.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_e;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_limit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == W'(MAX));
  assign cnt_o      = cnt_q;

  // Clear wins over increment when both are asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, one transaction in flight.
// Handshake: a requester holds req and its fields until its rvalid pulse; mem_req is held until mem_gnt.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic [1:0]          dbg_state,
  output logic [1:0]          dbg_owner,
  output logic [CNT_W-1:0]    dbg_wait_cnt
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                  cnt_inc, cnt_clr, cnt_at_limit;
  logic                  pick_if, owner_req;

  arb_starve_cnt #(
    .MAX (MAX_WAIT),
    .W   (CNT_W)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (cnt_inc),
    .clr_i      (cnt_clr),
    .cnt_o      (dbg_wait_cnt),
    .at_limit_o (cnt_at_limit)
  );

  // Data wins unless fetch is alone or has been passed over MAX_WAIT times.
  assign pick_if   = if_req && (!d_req || cnt_at_limit);
  assign owner_req = (owner_q == OWN_IF) ? if_req : d_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = !if_req;
        if (pick_if) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '1;
          cnt_clr     = 1'b1;
          state_d     = ST_REQ;
        end else if (d_req) begin
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          cnt_inc     = if_req;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (!owner_req) begin
          // Flush withdrew the request before memory accepted it.
          mem_req_d = 1'b0;
          owner_d   = OWN_NONE;
          state_d   = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          owner_d = OWN_NONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // Responses are routed in the same cycle; the pulse is delivered even if the owner has since dropped req.
  assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF) && mem_rvalid;
  assign d_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_DATA) && mem_rvalid;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = d_req & ~d_rvalid;

  assign dbg_state = state_q;
  assign dbg_owner = owner_q;

endmodule
